ram_fifo_ctrl: RTL

- Initiator side of the single-port synchronous RAM interface. Drives the RAM's address, write_enable and data_in, and consumes its registered data_out.
- Turns one external single-port RAM into a FIFO with a valid/ready input stream and a valid/ready output stream.
- Issues at most one RAM operation per cycle, arbitrating between reads and writes, and absorbs the RAM's 1-cycle read latency in a 2-entry output buffer.

---
 rtl/ram_fifo_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller built on one external single-port synchronous RAM.
// Reads and writes share the RAM port; a 2-entry buffer hides the read latency.
module ram_fifo_ctrl #(
    parameter int data_width    = 8,
    parameter int address_width = 7,
    parameter int depth         = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [data_width-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [data_width-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [address_width+1:0]   count,
    output logic [address_width-1:0]   ram_address,
    output logic [data_width-1:0]      ram_data_in,
    output logic                       ram_write_enable,
    input  logic [data_width-1:0]      ram_data_out
);

    localparam logic [address_width:0]   depth_count = (address_width+1)'(depth);
    localparam logic [address_width-1:0] ptr_one     = (address_width)'(1);
    localparam logic [address_width:0]   mem_one     = (address_width+1)'(1);

    logic [address_width-1:0] wr_ptr_reg;
    logic [address_width-1:0] rd_ptr_reg;
    logic [address_width:0]   mem_count_reg;
    logic [address_width:0]   mem_count_next;
    logic                     inflight_reg;
    logic                     prio_reg;
    logic                     out_valid_reg;
    logic [1:0]               occ_reg;
    logic [1:0]               occ_next;
    logic [1:0]               occ_after_pop;
    logic [data_width-1:0]    buf_reg [2];
    logic [data_width-1:0]    buf_next [2];
    logic [address_width+1:0] count_reg;
    logic [address_width+1:0] count_next;

    logic [1:0] pending;
    logic       mem_full;
    logic       read_req;
    logic       in_ready_c;
    logic       wr_grant;
    logic       rd_grant;
    logic       contested;
    logic       pop;

    // A read is only worth issuing if its word will have a buffer slot waiting.
    always_comb begin
        pending    = occ_reg + {1'b0, inflight_reg};
        mem_full   = (mem_count_reg == depth_count);
        read_req   = (mem_count_reg != '0) && (pending < 2'd2);
        in_ready_c = rst_n && !mem_full && !(read_req && !prio_reg);
        wr_grant   = in_valid && in_ready_c;
        rd_grant   = read_req && !wr_grant;
        contested  = read_req && in_valid && !mem_full;
        pop        = out_valid_reg && out_ready;
    end

    always_comb begin
        mem_count_next = mem_count_reg;
        if (wr_grant) begin
            mem_count_next = mem_count_reg + mem_one;
        end else if (rd_grant) begin
            mem_count_next = mem_count_reg - mem_one;
        end
    end

    // Pop shifts the head out first; the returning read word lands just past the survivors.
    always_comb begin
        occ_after_pop = occ_reg - {1'b0, pop};
        occ_next      = occ_after_pop + {1'b0, inflight_reg};
        for (int i = 0; i < 2; i++) begin
            buf_next[i] = buf_reg[i];
        end
        if (pop) begin
            buf_next[0] = buf_reg[1];
        end
        if (inflight_reg) begin
            buf_next[occ_after_pop[0]] = ram_data_out;
        end
        count_next = (address_width+2)'(mem_count_next)
                   + (address_width+2)'(rd_grant)
                   + (address_width+2)'(occ_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
            inflight_reg  <= 1'b0;
            prio_reg      <= 1'b0;
            occ_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
            buf_reg[0]    <= '0;
            buf_reg[1]    <= '0;
        end else begin
            if (wr_grant) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_one;
            end
            if (rd_grant) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_one;
            end
            if (contested) begin
                prio_reg <= !prio_reg;
            end
            mem_count_reg <= mem_count_next;
            inflight_reg  <= rd_grant;
            occ_reg       <= occ_next;
            out_valid_reg <= (occ_next != 2'd0);
            count_reg     <= count_next;
            buf_reg[0]    <= buf_next[0];
            buf_reg[1]    <= buf_next[1];
        end
    end

    assign in_ready         = in_ready_c;
    assign out_data         = buf_reg[0];
    assign out_valid        = out_valid_reg;
    assign count            = count_reg;
    assign ram_write_enable = wr_grant;
    assign ram_address      = wr_grant ? wr_ptr_reg : rd_ptr_reg;
    assign ram_data_in      = in_data;

endmodule
